ocp_arb2: RTL and testbench

Two-master, one-slave OCP arbiter that shares a single slave, typically `interval_timer`, between two bus masters, e.g. the CPU data port and a debug/DMA port. It applies round-robin arbitration, forwards the winner's command, and routes the response back to that master only. It holds the grant until the transaction completes and guards reads with a response timeout.

---
 rtl/ocp_arb2_pkg.sv | 44 ++++
 rtl/ocp_arb2.sv | 153 +++++++++++++++
 tb/tb_ocp_arb2.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocp_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ocp_arb2_pkg
// Description : Shared bus widths, OCP command/response codes, arbiter state
//               encoding and the two-way round-robin pick function used by
//               ocp_arb2.
// Revision    : 1.0 - initial release
// ============================================================================
package ocp_arb2_pkg;

  // Bus widths
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = 4;

  // OCP command codes
  localparam logic [2:0] OCP_CMD_IDLE = 3'b000;
  localparam logic [2:0] OCP_CMD_WR   = 3'b001;
  localparam logic [2:0] OCP_CMD_RD   = 3'b010;

  // OCP response codes
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Round-robin pick between two requesters. Returns the index of the
  // winner (0 or 1); when both request, the one that did not win last time
  // is chosen. With no request the result is 0 and must be qualified by the
  // caller.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    return req1 && (!req0 || !last);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ocp_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ocp_arb2
// Description : Two-master / one-slave OCP arbiter. Round-robin grant in
//               IDLE, grant held until the transaction completes, response
//               routed to the granted master only, read response timeout.
// Ports       : clk, nrst                    - clock, async active-low reset
//               i_m{0,1}_MAddr/MCmd/MData/MByteEn - master commands
//               o_m{0,1}_SCmdAccept/SData/SResp    - per-master responses
//               o_MAddr/MCmd/MData/MByteEn - command to the slave
//               i_SCmdAccept/SData/SResp   - slave accept and response
// Revision    : 1.0 - initial release
// ============================================================================
module ocp_arb2
  import ocp_arb2_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] i_m0_MAddr,
  input  logic [2:0]            i_m0_MCmd,
  input  logic [DATA_WIDTH-1:0] i_m0_MData,
  input  logic [BEN_WIDTH-1:0]  i_m0_MByteEn,
  output logic                  o_m0_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_m0_SData,
  output logic [1:0]            o_m0_SResp,
  // master 1
  input  logic [ADDR_WIDTH-1:0] i_m1_MAddr,
  input  logic [2:0]            i_m1_MCmd,
  input  logic [DATA_WIDTH-1:0] i_m1_MData,
  input  logic [BEN_WIDTH-1:0]  i_m1_MByteEn,
  output logic                  o_m1_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_m1_SData,
  output logic [1:0]            o_m1_SResp,
  // slave
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT);
  // The error is returned in the cycle where this is the count of RESP
  // cycles already elapsed, so it lands TIMEOUT cycles after the accept.
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e       r_state, w_state_nxt;
  logic             r_last;   // master that won the last accepted command
  logic             r_gnt;    // locked grant for CMD/RESP
  logic [CNT_W-1:0] r_cnt;

  logic w_req0, w_req1, w_any;
  logic w_sel, w_fwd, w_acc, w_is_rd, w_in_resp, w_tmo, w_resp_hit;
  logic [2:0] w_sel_cmd;

  assign w_req0 = (i_m0_MCmd != OCP_CMD_IDLE);
  assign w_req1 = (i_m1_MCmd != OCP_CMD_IDLE);
  assign w_any  = w_req0 || w_req1;

  // In IDLE the grant is decided combinationally; afterwards it is locked.
  assign w_sel     = (r_state == ARB_IDLE) ? rr_pick(w_req0, w_req1, r_last) : r_gnt;
  assign w_sel_cmd = w_sel ? i_m1_MCmd : i_m0_MCmd;
  assign w_is_rd   = (w_sel_cmd == OCP_CMD_RD);

  // Outputs are qualified with nrst so they reach reset values as soon as
  // reset asserts, not only once the state register has been cleared.
  assign w_fwd      = nrst && (((r_state == ARB_IDLE) && w_any) || (r_state == ARB_CMD));
  assign w_acc      = w_fwd && i_SCmdAccept;
  assign w_in_resp  = nrst && (r_state == ARB_RESP);
  assign w_resp_hit = (i_SResp != OCP_RESP_NULL);
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == c_tmo_last);

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          if (i_SCmdAccept) w_state_nxt = w_is_rd ? ARB_RESP : ARB_IDLE;
          else              w_state_nxt = ARB_CMD;
        end
      end
      ARB_CMD: begin
        if (i_SCmdAccept) w_state_nxt = w_is_rd ? ARB_RESP : ARB_IDLE;
      end
      ARB_RESP: begin
        if (w_resp_hit || w_tmo) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Slave-side command and per-master outputs
  always_comb begin
    o_MCmd          = OCP_CMD_IDLE;
    o_MAddr         = '0;
    o_MData         = '0;
    o_MByteEn       = '0;
    o_m0_SCmdAccept = 1'b0;
    o_m1_SCmdAccept = 1'b0;
    o_m0_SResp      = OCP_RESP_NULL;
    o_m1_SResp      = OCP_RESP_NULL;
    o_m0_SData      = '0;
    o_m1_SData      = '0;

    if (w_fwd) begin
      o_MCmd    = w_sel_cmd;
      o_MAddr   = w_sel ? i_m1_MAddr   : i_m0_MAddr;
      o_MData   = w_sel ? i_m1_MData   : i_m0_MData;
      o_MByteEn = w_sel ? i_m1_MByteEn : i_m0_MByteEn;
      if (w_sel) o_m1_SCmdAccept = i_SCmdAccept;
      else       o_m0_SCmdAccept = i_SCmdAccept;
    end

    // A real response wins over a timeout that falls in the same cycle.
    if (w_in_resp) begin
      if (w_resp_hit) begin
        if (r_gnt) begin o_m1_SResp = i_SResp; o_m1_SData = i_SData; end
        else       begin o_m0_SResp = i_SResp; o_m0_SData = i_SData; end
      end else if (w_tmo) begin
        if (r_gnt) o_m1_SResp = OCP_RESP_ERR;
        else       o_m0_SResp = OCP_RESP_ERR;
      end
    end
  end

  // State, grant lock, round-robin pointer and response counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_any) r_gnt <= w_sel;
      if (w_acc) r_last <= w_sel;
      if (r_state != ARB_RESP && w_state_nxt == ARB_RESP) begin
        r_cnt <= '0;
      end else if (r_state == ARB_RESP && r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ocp_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ocp_arb2
// Description : Self-checking bench for ocp_arb2 with a small register slave
//               (CTRL 0x000, CNTR 0x004, CURR 0x008) that can stall its
//               accept or withhold read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocp_arb2;
  import ocp_arb2_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_WIDTH-1:0] m0_addr = '0, m1_addr = '0, s_addr;
  logic [2:0]            m0_cmd = OCP_CMD_IDLE, m1_cmd = OCP_CMD_IDLE, s_cmd;
  logic [DATA_WIDTH-1:0] m0_data = '0, m1_data = '0, s_mdata;
  logic [BEN_WIDTH-1:0]  m0_ben = '0, m1_ben = '0, s_ben;
  logic                  m0_acc, m1_acc, s_acc;
  logic [DATA_WIDTH-1:0] m0_sdata, m1_sdata, s_sdata;
  logic [1:0]            m0_resp, m1_resp, s_resp;

  ocp_arb2 #(.TIMEOUT(16)) dut (
    .clk(clk), .nrst(nrst),
    .i_m0_MAddr(m0_addr), .i_m0_MCmd(m0_cmd), .i_m0_MData(m0_data), .i_m0_MByteEn(m0_ben),
    .o_m0_SCmdAccept(m0_acc), .o_m0_SData(m0_sdata), .o_m0_SResp(m0_resp),
    .i_m1_MAddr(m1_addr), .i_m1_MCmd(m1_cmd), .i_m1_MData(m1_data), .i_m1_MByteEn(m1_ben),
    .o_m1_SCmdAccept(m1_acc), .o_m1_SData(m1_sdata), .o_m1_SResp(m1_resp),
    .o_MAddr(s_addr), .o_MCmd(s_cmd), .o_MData(s_mdata), .o_MByteEn(s_ben),
    .i_SCmdAccept(s_acc), .i_SData(s_sdata), .i_SResp(s_resp)
  );

  // ---------------- slave model ----------------
  int   stall_cfg = 0;   // cycles a pending command waits before accept
  bit   no_resp   = 1'b0;
  int   wait_cnt;
  logic [31:0] regs [3];
  logic        rv;
  logic [31:0] rd;

  assign s_acc   = (s_cmd != OCP_CMD_IDLE) && (wait_cnt >= stall_cfg);
  assign s_resp  = rv ? OCP_RESP_DVA : OCP_RESP_NULL;
  assign s_sdata = rv ? rd : 32'h0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= 0; rv <= 1'b0; rd <= '0;
      for (int k = 0; k < 3; k++) regs[k] <= '0;
    end else begin
      rv <= 1'b0;
      if (s_acc) wait_cnt <= 0;
      else if (s_cmd != OCP_CMD_IDLE) wait_cnt <= wait_cnt + 1;
      if (s_acc && s_addr[3:2] != 2'd3) begin
        if (s_cmd == OCP_CMD_WR) regs[s_addr[3:2]] <= s_mdata;
        if (s_cmd == OCP_CMD_RD && !no_resp) begin
          rv <= 1'b1; rd <= regs[s_addr[3:2]];
        end
      end
    end
  end

  // ---------------- observers ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gq[$];
  int r0 = 0, r1 = 0, a1 = 0;
  always @(negedge clk) begin
    if (nrst) begin
      if (m0_acc) gq.push_back(0);
      if (m1_acc) begin gq.push_back(1); a1 <= a1 + 1; end
      if (m0_resp != OCP_RESP_NULL) r0 <= r0 + 1;
      if (m1_resp != OCP_RESP_NULL) r1 <= r1 + 1;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int m, input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data);
    if (m == 0) begin m0_cmd = cmd; m0_addr = addr; m0_data = data; m0_ben = 4'hf; end
    else        begin m1_cmd = cmd; m1_addr = addr; m1_data = data; m1_ben = 4'hf; end
  endtask

  // Issue one command (caller is at posedge+#1) and wait for accept and,
  // for reads, the response. Returns at posedge+#1.
  task automatic mst_txn(input int m, input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, output logic [1:0] resp,
                         output logic [31:0] rdata, output int t_iss, output int t_acc,
                         output int t_rsp);
    bit seen = 1'b0;
    t_iss = cyc; t_acc = -1; t_rsp = -1; resp = OCP_RESP_NULL; rdata = '0;
    drive(m, cmd, addr, data);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_acc : m1_acc) begin seen = 1'b1; t_acc = cyc; end
      @(posedge clk); #1;
    end
    drive(m, OCP_CMD_IDLE, '0, '0);
    check($sformatf("m%0d_accept_seen", m), {31'd0, seen}, 32'd1);
    if (seen && cmd == OCP_CMD_RD) begin
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (((m == 0) ? m0_resp : m1_resp) != OCP_RESP_NULL) begin
          seen = 1'b1; t_rsp = cyc;
          resp  = (m == 0) ? m0_resp  : m1_resp;
          rdata = (m == 0) ? m0_sdata : m1_sdata;
        end
      end
      check($sformatf("m%0d_resp_seen", m), {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  logic [1:0]  ra, rb;
  logic [31:0] da, db;
  int ia, aa, pa, ib, ab, pb;
  int s0, s1, sa;

  initial begin
    // ---- reset state, with m0 already requesting ----
    drive(0, OCP_CMD_WR, 32'h4, 32'h55);
    #12;
    check("rst_mcmd",  {29'd0, s_cmd}, {29'd0, OCP_CMD_IDLE});
    check("rst_maddr", s_addr, 32'h0);
    check("rst_mdata", s_mdata, 32'h0);
    check("rst_m0acc", {31'd0, m0_acc}, 32'd0);
    check("rst_m0resp", {30'd0, m0_resp}, {30'd0, OCP_RESP_NULL});
    check("rst_m1sdata", m1_sdata, 32'h0);
    drive(0, OCP_CMD_IDLE, '0, '0);
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;

    // ---- simultaneous reads out of reset: m0 first ----
    gq.delete(); s0 = r0; s1 = r1;
    fork
      mst_txn(0, OCP_CMD_RD, 32'h0, 32'h0, ra, da, ia, aa, pa);
      mst_txn(1, OCP_CMD_RD, 32'h0, 32'h0, rb, db, ib, ab, pb);
    join
    check("sim_ngrant", gq.size(), 2);
    if (gq.size() == 2) begin
      check("sim_first", gq[0], 0);
      check("sim_second", gq[1], 1);
    end
    check("sim_m0_dva", {30'd0, ra}, {30'd0, OCP_RESP_DVA});
    check("sim_m1_dva", {30'd0, rb}, {30'd0, OCP_RESP_DVA});
    check("sim_m0_once", r0 - s0, 1);
    check("sim_m1_once", r1 - s1, 1);

    // ---- single write then readback by m0 ----
    s1 = r1; sa = a1;
    drive(0, OCP_CMD_WR, 32'h4, 32'h10);
    @(negedge clk);
    check("wr_fwd_cmd",  {29'd0, s_cmd}, {29'd0, OCP_CMD_WR});
    check("wr_fwd_addr", s_addr, 32'h4);
    check("wr_fwd_data", s_mdata, 32'h10);
    check("wr_fwd_ben",  {28'd0, s_ben}, 32'hf);
    check("wr_m0_acc",   {31'd0, m0_acc}, 32'd1);
    check("wr_m1_noacc", {31'd0, m1_acc}, 32'd0);
    @(posedge clk); #1; drive(0, OCP_CMD_IDLE, '0, '0);
    mst_txn(0, OCP_CMD_RD, 32'h4, 32'h0, ra, da, ia, aa, pa);
    check("rb_resp", {30'd0, ra}, {30'd0, OCP_RESP_DVA});
    check("rb_data", da, 32'h10);
    check("rb_latency", pa - aa, 1);
    check("wr_m1_noresp", r1 - s1, 0);
    check("wr_m1_noacc_all", a1 - sa, 0);

    // ---- lock in CMD: slave stalls 3 cycles, m1 arrives meanwhile ----
    gq.delete(); stall_cfg = 3;
    fork
      mst_txn(0, OCP_CMD_RD, 32'h4, 32'h0, ra, da, ia, aa, pa);
      begin
        @(posedge clk); #1;
        mst_txn(1, OCP_CMD_WR, 32'h8, 32'h77, rb, db, ib, ab, pb);
      end
    join
    stall_cfg = 0;
    check("lock_stall", aa - ia, 3);
    check("lock_ngrant", gq.size(), 2);
    if (gq.size() == 2) begin
      check("lock_first", gq[0], 0);
      check("lock_second", gq[1], 1);
    end
    check("lock_m0_data", da, 32'h10);
    check("lock_m1_after", {31'd0, ab > pa}, 32'd1);

    // ---- timeout: slave never answers ----
    no_resp = 1'b1;
    mst_txn(0, OCP_CMD_RD, 32'h0, 32'h0, ra, da, ia, aa, pa);
    no_resp = 1'b0;
    check("tmo_resp", {30'd0, ra}, {30'd0, OCP_RESP_ERR});
    check("tmo_data", da, 32'h0);
    check("tmo_delay", pa - aa, 16);
    mst_txn(1, OCP_CMD_WR, 32'h8, 32'h1, rb, db, ib, ab, pb);
    check("tmo_back_idle", ab - ib, 0);

    // ---- alternation: 3 writes from each master, continuous ----
    gq.delete();
    fork
      for (int k = 0; k < 3; k++) mst_txn(0, OCP_CMD_WR, 32'h0, k, ra, da, ia, aa, pa);
      for (int k = 0; k < 3; k++) mst_txn(1, OCP_CMD_WR, 32'h8, k, rb, db, ib, ab, pb);
    join
    check("alt_ngrant", gq.size(), 6);
    if (gq.size() == 6)
      for (int k = 0; k < 6; k++) check($sformatf("alt_g%0d", k), gq[k], k % 2);

    // ---- reset during RESP, m1 waiting ----
    no_resp = 1'b1;
    drive(0, OCP_CMD_RD, 32'h8, 32'h0);
    @(negedge clk);
    check("rst_pre_acc", {31'd0, m0_acc}, 32'd1);
    @(posedge clk); #1;
    drive(0, OCP_CMD_IDLE, '0, '0);
    drive(1, OCP_CMD_WR, 32'h4, 32'hAA);
    @(negedge clk);
    check("rst_resp_hold", {29'd0, s_cmd}, {29'd0, OCP_CMD_IDLE});
    #2 nrst = 1'b0; #1;
    check("mid_rst_mcmd",  {29'd0, s_cmd}, {29'd0, OCP_CMD_IDLE});
    check("mid_rst_maddr", s_addr, 32'h0);
    check("mid_rst_mdata", s_mdata, 32'h0);
    check("mid_rst_mben",  {28'd0, s_ben}, 32'h0);
    check("mid_rst_m1acc", {31'd0, m1_acc}, 32'd0);
    check("mid_rst_m0resp", {30'd0, m0_resp}, {30'd0, OCP_RESP_NULL});
    check("mid_rst_m0data", m0_sdata, 32'h0);
    drive(1, OCP_CMD_IDLE, '0, '0);
    no_resp = 1'b0;
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;
    gq.delete();
    fork
      mst_txn(0, OCP_CMD_WR, 32'h4, 32'h3, ra, da, ia, aa, pa);
      mst_txn(1, OCP_CMD_WR, 32'h4, 32'h4, rb, db, ib, ab, pb);
    join
    check("post_rst_ngrant", gq.size(), 2);
    if (gq.size() == 2) check("post_rst_first", gq[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
